jtag_tap_target: RTL and testbench

// - Target-side JTAG TAP controller; the responder to the simulated JTAG host.
// - Oversamples TCK/TMS/TDI in the clk domain and runs the IEEE 1149.1 16-state TAP FSM.
// - Holds the IR and a DR shift register and presents parallel capture/update strobes
//   to the on-chip debug logic (debug controller).
// - Provides BYPASS and IDCODE internally; every other instruction uses the external DR path.

---
 rtl/jtag_pkg.sv | 32 +++
 rtl/jtag_tap_target_sync.sv | 29 ++
 rtl/jtag_tap_target.sv | 162 ++++++++++++++++
 tb/tb_jtag_tap_target.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// jtag_pkg : TAP state encoding and built-in instruction codes
// Rev 1.0
// ------------------------------------------------------------------
package jtag_pkg;

   typedef enum logic [3:0] {
      TEST_LOGIC_RESET = 4'd0,
      RUN_TEST_IDLE    = 4'd1,
      SELECT_DR_SCAN   = 4'd2,
      CAPTURE_DR       = 4'd3,
      SHIFT_DR         = 4'd4,
      EXIT1_DR         = 4'd5,
      PAUSE_DR         = 4'd6,
      EXIT2_DR         = 4'd7,
      UPDATE_DR        = 4'd8,
      SELECT_IR_SCAN   = 4'd9,
      CAPTURE_IR       = 4'd10,
      SHIFT_IR         = 4'd11,
      EXIT1_IR         = 4'd12,
      PAUSE_IR         = 4'd13,
      EXIT2_IR         = 4'd14,
      UPDATE_IR        = 4'd15
   } jtag_state_t;

   // Width-agnostic codes; -1 truncates to all ones at any IR width.
   localparam int INSTR_IDCODE = 1;
   localparam int INSTR_BYPASS = -1;

endpackage
`default_nettype wire

// File: rtl/jtag_tap_target_sync.sv
`default_nettype none
// ------------------------------------------------------------------
// jtag_tap_target_sync : 2-flop synchronizer for one asynchronous pin
// Rev 1.0
// ------------------------------------------------------------------
module jtag_tap_target_sync (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/jtag_tap_target.sv
`default_nettype none
// ------------------------------------------------------------------
// jtag_tap_target : oversampled IEEE 1149.1 TAP with BYPASS/IDCODE
// Rev 1.0
// ------------------------------------------------------------------
module jtag_tap_target
   import jtag_pkg::*;
#(
   parameter int          INSTRUCTION_WIDTH = 4,
   parameter int          DATA_WIDTH        = 64,
   parameter logic [31:0] JTAG_ID           = 32'h4d20dffb
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         jtag_tck,
   input  logic                         jtag_tms,
   input  logic                         jtag_tdi,
   input  logic                         jtag_trst,
   output logic                         jtag_tdo,
   output logic [INSTRUCTION_WIDTH-1:0] instruction,
   output logic                         capture_dr,
   output logic                         update_dr,
   output logic                         update_ir,
   input  logic [DATA_WIDTH-1:0]        capture_data,
   output logic [DATA_WIDTH-1:0]        update_data
);

   localparam logic [INSTRUCTION_WIDTH-1:0] c_idcode = INSTRUCTION_WIDTH'(INSTR_IDCODE);
   localparam logic [INSTRUCTION_WIDTH-1:0] c_bypass = INSTRUCTION_WIDTH'(INSTR_BYPASS);

   logic [3:0] w_async;
   logic [3:0] w_sync;
   logic       w_tck, w_tms, w_tdi, w_trst;
   logic       w_tck_rise, w_tck_fall, w_is_ext;

   jtag_state_t                  r_state, w_state_next;
   logic                         r_tck_prev;
   logic [INSTRUCTION_WIDTH-1:0] r_ir;
   logic [INSTRUCTION_WIDTH-1:0] r_instruction;
   logic [DATA_WIDTH-1:0]        r_dr;
   logic                         r_tdo, r_capture_dr, r_update_dr, r_update_ir;

   assign w_async = {jtag_trst, jtag_tdi, jtag_tms, jtag_tck};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sync
         jtag_tap_target_sync u_sync (
            .clk   (clk),
            .reset (reset),
            .i_d   (w_async[gi]),
            .o_q   (w_sync[gi])
         );
      end
   endgenerate

   assign w_tck      = w_sync[0];
   assign w_tms      = w_sync[1];
   assign w_tdi      = w_sync[2];
   assign w_trst     = w_sync[3];
   assign w_tck_rise = w_tck & ~r_tck_prev;
   assign w_tck_fall = ~w_tck & r_tck_prev;
   assign w_is_ext   = (r_instruction != c_idcode) && (r_instruction != c_bypass);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= TEST_LOGIC_RESET;
      end else if (w_trst) begin
         r_state <= TEST_LOGIC_RESET;
      end else if (w_tck_rise) begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         TEST_LOGIC_RESET: w_state_next = w_tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
         RUN_TEST_IDLE:    w_state_next = w_tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_DR_SCAN:   w_state_next = w_tms ? SELECT_IR_SCAN   : CAPTURE_DR;
         CAPTURE_DR:       w_state_next = w_tms ? EXIT1_DR         : SHIFT_DR;
         SHIFT_DR:         w_state_next = w_tms ? EXIT1_DR         : SHIFT_DR;
         EXIT1_DR:         w_state_next = w_tms ? UPDATE_DR        : PAUSE_DR;
         PAUSE_DR:         w_state_next = w_tms ? EXIT2_DR         : PAUSE_DR;
         EXIT2_DR:         w_state_next = w_tms ? UPDATE_DR        : SHIFT_DR;
         UPDATE_DR:        w_state_next = w_tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_IR_SCAN:   w_state_next = w_tms ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       w_state_next = w_tms ? EXIT1_IR         : SHIFT_IR;
         SHIFT_IR:         w_state_next = w_tms ? EXIT1_IR         : SHIFT_IR;
         EXIT1_IR:         w_state_next = w_tms ? UPDATE_IR        : PAUSE_IR;
         PAUSE_IR:         w_state_next = w_tms ? EXIT2_IR         : PAUSE_IR;
         EXIT2_IR:         w_state_next = w_tms ? UPDATE_IR        : SHIFT_IR;
         UPDATE_IR:        w_state_next = w_tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         default:          w_state_next = TEST_LOGIC_RESET;
      endcase
   end

   // Actions are keyed on the state being exited at each synchronized TCK rise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tck_prev    <= 1'b0;
         r_ir          <= '0;
         r_dr          <= '0;
         r_instruction <= c_idcode;
         r_tdo         <= 1'b0;
         r_capture_dr  <= 1'b0;
         r_update_dr   <= 1'b0;
         r_update_ir   <= 1'b0;
      end else begin
         r_tck_prev   <= w_tck;
         r_capture_dr <= 1'b0;
         r_update_dr  <= 1'b0;
         r_update_ir  <= 1'b0;
         if (w_trst) begin
            r_instruction <= c_idcode;
         end else if (w_tck_rise) begin
            case (r_state)
               CAPTURE_IR: r_ir <= INSTRUCTION_WIDTH'(1);
               SHIFT_IR:   r_ir <= {w_tdi, r_ir[INSTRUCTION_WIDTH-1:1]};
               UPDATE_IR: begin
                  r_instruction <= r_ir;
                  r_update_ir   <= 1'b1;
               end
               CAPTURE_DR: begin
                  if (r_instruction == c_bypass) begin
                     r_dr <= '0;
                  end else if (r_instruction == c_idcode) begin
                     r_dr <= DATA_WIDTH'(JTAG_ID);
                  end else begin
                     r_dr         <= capture_data;
                     r_capture_dr <= 1'b1;
                  end
               end
               SHIFT_DR: begin
                  if (r_instruction == c_bypass) begin
                     r_dr[0] <= w_tdi;
                  end else if (r_instruction == c_idcode) begin
                     r_dr[31:0] <= {w_tdi, r_dr[31:1]};
                  end else begin
                     r_dr <= {w_tdi, r_dr[DATA_WIDTH-1:1]};
                  end
               end
               UPDATE_DR:  r_update_dr <= w_is_ext;
               default: ;
            endcase
            if (w_state_next == TEST_LOGIC_RESET) begin
               r_instruction <= c_idcode;
            end
         end else if (w_tck_fall) begin
            r_tdo <= (r_state == SHIFT_IR) ? r_ir[0] : r_dr[0];
         end
      end
   end

   assign jtag_tdo    = r_tdo;
   assign instruction = r_instruction;
   assign capture_dr  = r_capture_dr;
   assign update_dr   = r_update_dr;
   assign update_ir   = r_update_ir;
   assign update_data = r_dr;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_target.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_jtag_tap_target : directed JTAG host with queue-based scoreboard
// Rev 1.0
// ------------------------------------------------------------------
module tb_jtag_tap_target;
   import jtag_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        jtag_tck = 1'b0;
   logic        jtag_tms = 1'b1;
   logic        jtag_tdi = 1'b0;
   logic        jtag_trst = 1'b0;
   logic        jtag_tdo;
   logic [3:0]  instruction;
   logic        capture_dr, update_dr, update_ir;
   logic [63:0] capture_data = '0;
   logic [63:0] update_data;

   int n_cmp = 0;
   int n_bad = 0;

   logic [3:0]  q_ir[$];
   logic [3:0]  q_cap[$];
   logic [63:0] q_upd[$];
   logic        q_tdo[$];
   logic        smp = 1'b0;

   jtag_tap_target #(
      .INSTRUCTION_WIDTH (4),
      .DATA_WIDTH        (64),
      .JTAG_ID           (32'h4d20dffb)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .jtag_tck     (jtag_tck),
      .jtag_tms     (jtag_tms),
      .jtag_tdi     (jtag_tdi),
      .jtag_trst    (jtag_trst),
      .jtag_tdo     (jtag_tdo),
      .instruction  (instruction),
      .capture_dr   (capture_dr),
      .update_dr    (update_dr),
      .update_ir    (update_ir),
      .capture_data (capture_data),
      .update_data  (update_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Strobe monitor: every pulse must match a pending expectation.
   always @(negedge clk) begin
      if (update_ir) begin
         n_cmp++;
         if (q_ir.size() == 0) begin
            n_bad++;
            $display("FAIL update_ir: unexpected pulse, instruction %h", instruction);
         end else begin
            logic [3:0] e;
            e = q_ir.pop_front();
            if (instruction !== e) begin
               n_bad++;
               $display("FAIL update_ir: instruction %h expected %h", instruction, e);
            end
         end
      end
      if (capture_dr) begin
         n_cmp++;
         if (q_cap.size() == 0) begin
            n_bad++;
            $display("FAIL capture_dr: unexpected pulse, instruction %h", instruction);
         end else begin
            logic [3:0] e;
            e = q_cap.pop_front();
            if (instruction !== e) begin
               n_bad++;
               $display("FAIL capture_dr: instruction %h expected %h", instruction, e);
            end
         end
      end
      if (update_dr) begin
         n_cmp++;
         if (q_upd.size() == 0) begin
            n_bad++;
            $display("FAIL update_dr: unexpected pulse, update_data %h", update_data);
         end else begin
            logic [63:0] e;
            e = q_upd.pop_front();
            if (update_data !== e) begin
               n_bad++;
               $display("FAIL update_dr: update_data %h expected %h", update_data, e);
            end
         end
      end
   end

   // TDO monitor: host samples TDO on shift rises.
   always @(posedge jtag_tck) begin
      if (smp) begin
         n_cmp++;
         if (q_tdo.size() == 0) begin
            n_bad++;
            $display("FAIL tdo: sample with no expectation, got %b", jtag_tdo);
         end else begin
            logic e;
            e = q_tdo.pop_front();
            if (jtag_tdo !== e) begin
               n_bad++;
               $display("FAIL tdo: got %b expected %b", jtag_tdo, e);
            end
         end
      end
   end

   task automatic tck_pulse(input logic tms, input logic tdi, input logic sample, input logic exp_tdo);
      jtag_tms = tms;
      jtag_tdi = tdi;
      smp      = sample;
      if (sample) q_tdo.push_back(exp_tdo);
      #40 jtag_tck = 1'b1;
      #80 jtag_tck = 1'b0;
      smp = 1'b0;
      #40;
   endtask

   task automatic ir_scan(input logic [3:0] v);
      logic [3:0] cap_pat;
      cap_pat = 4'b0001;
      tck_pulse(1, 0, 0, 0);
      tck_pulse(1, 0, 0, 0);
      tck_pulse(0, 0, 0, 0);
      tck_pulse(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) tck_pulse(i == 3, v[i], 1, cap_pat[i]);
      q_ir.push_back(v);
      tck_pulse(1, 0, 0, 0);
      tck_pulse(0, 0, 0, 0);
   endtask

   task automatic dr_scan(input int len, input logic [63:0] tdi_v, input logic [63:0] tdo_v,
                          input logic [3:0] ext_instr, input logic [63:0] cap, input logic [63:0] upd,
                          input int pause_at, input int abort_at);
      capture_data = cap;
      tck_pulse(1, 0, 0, 0);
      tck_pulse(0, 0, 0, 0);
      if (ext_instr != 4'h0) q_cap.push_back(ext_instr);
      tck_pulse(len == 0, 0, 0, 0);
      for (int i = 0; i < len; i++) begin
         if (i == abort_at) return;
         tck_pulse((i == len - 1) || (i == pause_at), tdi_v[i], 1, tdo_v[i]);
         if (i == pause_at) begin
            tck_pulse(0, 0, 0, 0);
            repeat (10) tck_pulse(0, 0, 0, 0);
            tck_pulse(1, 0, 0, 0);
            tck_pulse(0, 0, 0, 0);
         end
      end
      if (ext_instr != 4'h0) q_upd.push_back(upd);
      tck_pulse(1, 0, 0, 0);
      tck_pulse(0, 0, 0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      #35 reset = 1'b0;
      #100;
      check("reset instruction", 64'(instruction), 64'h1);
      check("reset tdo", 64'(jtag_tdo), 64'h0);
      check("reset update_data", update_data, 64'h0);
      check("reset state", 64'(dut.r_state), 64'(TEST_LOGIC_RESET));

      repeat (5) tck_pulse(1, 0, 0, 0);
      check("tms5 state", 64'(dut.r_state), 64'(TEST_LOGIC_RESET));
      check("tms5 instruction", 64'(instruction), 64'h1);
      tck_pulse(0, 0, 0, 0);

      // IDCODE: 32 bits shifted out LSB first.
      ir_scan(4'h1);
      dr_scan(32, 64'h0, 64'h4d20dffb, 4'h0, 64'h0, 64'h0, -1, -1);

      // BYPASS: one-bit delay line, leading zero from capture.
      ir_scan(4'hf);
      check("bypass instruction", 64'(instruction), 64'hf);
      dr_scan(9, 64'h0a5, 64'h14a, 4'h0, 64'h0, 64'h0, -1, -1);

      // External DR.
      ir_scan(4'h3);
      check("ext instruction", 64'(instruction), 64'h3);
      dr_scan(64, 64'hfedcba9876543210, 64'h0123456789abcdef, 4'h3,
              64'h0123456789abcdef, 64'hfedcba9876543210, -1, -1);

      // Same scan paused for 10 TCK mid-shift.
      dr_scan(64, 64'hfedcba9876543210, 64'hdeadbeefcafef00d, 4'h3,
              64'hdeadbeefcafef00d, 64'hfedcba9876543210, 20, -1);

      // Zero-length shift still updates with the captured value.
      dr_scan(0, 64'h0, 64'h0, 4'h3, 64'h5a5a_1234_a5a5_9876, 64'h5a5a_1234_a5a5_9876, -1, -1);

      // TRST mid-shift: no update strobe, back to reset with IDCODE.
      dr_scan(64, 64'hffff_0000_ffff_0000, 64'h1357_9bdf_2468_ace0, 4'h3,
              64'h1357_9bdf_2468_ace0, 64'h0, -1, 10);
      jtag_trst = 1'b1;
      #100 jtag_trst = 1'b0;
      #100;
      check("trst state", 64'(dut.r_state), 64'(TEST_LOGIC_RESET));
      check("trst instruction", 64'(instruction), 64'h1);
      tck_pulse(0, 0, 0, 0);

      // Async reset mid-shift discards the partial DR.
      ir_scan(4'h3);
      dr_scan(64, 64'h0f0f_0f0f_0f0f_0f0f, 64'h8888_4444_2222_1111, 4'h3,
              64'h8888_4444_2222_1111, 64'h0, -1, 10);
      reset = 1'b1;
      #30 reset = 1'b0;
      #100;
      check("areset state", 64'(dut.r_state), 64'(TEST_LOGIC_RESET));
      check("areset instruction", 64'(instruction), 64'h1);
      check("areset update_data", update_data, 64'h0);
      check("areset tdo", 64'(jtag_tdo), 64'h0);

      #200;
      check("q_ir drained", 64'(q_ir.size()), 64'h0);
      check("q_cap drained", 64'(q_cap.size()), 64'h0);
      check("q_upd drained", 64'(q_upd.size()), 64'h0);
      check("q_tdo drained", 64'(q_tdo.size()), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
